// File: rtl/l1_dcache_pkg.sv
// Shared encodings and helpers for the L1 dcache load/store adapter.
package l1_dcache_pkg;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_STORE = 2'b01,
    OP_AMO   = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_MISALIGN = 2'b01,
    CAUSE_PFAULT   = 2'b10
  } cause_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_XLATE,
    S_ISSUE,
    S_ERR
  } state_e;

  localparam int unsigned BE_MAX_W = 8;

  // Byte-enable mask for a naturally sized access placed at the lane offset.
  function automatic logic [BE_MAX_W-1:0] be_gen(input logic [1:0] size,
                                                 input logic [2:0] offset);
    logic [BE_MAX_W-1:0] mask;
    case (size)
      2'd0:    mask = 8'h01;
      2'd1:    mask = 8'h03;
      2'd2:    mask = 8'h0F;
      default: mask = 8'hFF;
    endcase
    return mask << offset;
  endfunction

endpackage

// File: rtl/l1_dcache_req_fifo.sv
// Request FIFO with registered ready/empty flags; no push/pop bypass.
module l1_dcache_req_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     ready_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ready_q, empty_q;
  logic             do_push, do_pop;

  assign do_push = push_i && ready_q;
  assign do_pop  = pop_i && !empty_q;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      ready_q <= (count_d != CNT_W'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  // Storage needs no reset: entries are only read while count says valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign ready_o = ready_q;
  assign empty_o = empty_q;
  assign count_o = count_q;

endmodule

// File: rtl/l1_dcache_lsq_adapter.sv
// Core memory-stage to MMU/L1-dcache adapter: queue, check, translate, issue.
module l1_dcache_lsq_adapter
  import l1_dcache_pkg::*;
#(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned PADDR_W = 56,
  parameter int unsigned INDEX_W = 11,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [1:0]                 req_op_i,
  input  logic [63:0]                req_vaddr_i,
  input  logic [XLEN-1:0]            req_wdata_i,
  input  logic [1:0]                 req_size_i,
  output logic                       xlat_req_o,
  output logic [63:0]                xlat_vaddr_o,
  input  logic                       xlat_valid_i,
  input  logic                       xlat_fault_i,
  input  logic [PADDR_W-1:0]         xlat_paddr_i,
  output logic                       dc_req_valid_o,
  input  logic                       dc_req_ready_i,
  output logic                       dc_req_we_o,
  output logic [INDEX_W-1:0]         dc_req_index_o,
  output logic [PADDR_W-INDEX_W-1:0] dc_req_tag_o,
  output logic [XLEN-1:0]            dc_req_wdata_o,
  output logic [XLEN/8-1:0]          dc_req_be_o,
  output logic [1:0]                 dc_req_size_o,
  output logic                       err_valid_o,
  output logic [1:0]                 err_cause_o,
  output logic [63:0]                err_vaddr_o,
  output logic                       empty_o,
  output logic                       drain_nc_o
);
  localparam int unsigned OFF_W = $clog2(XLEN/8);
  localparam int unsigned BE_W  = XLEN/8;
  localparam int unsigned TAG_W = PADDR_W - INDEX_W;
  localparam int unsigned ENT_W = 2 + 64 + XLEN + 2;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              push, pop_c, remain, misalign, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [ENT_W-1:0]  head;
  logic [1:0]        head_op, head_size;
  logic [63:0]       head_vaddr;
  logic [XLEN-1:0]   head_wdata;
  logic [OFF_W-1:0]  head_off;

  state_e             state_q, state_d;
  logic               xlat_req_q, xlat_req_d, dc_valid_q, dc_valid_d;
  logic               err_valid_q, err_valid_d, empty_q, empty_d, dc_we_q, dc_we_d;
  logic [63:0]        xlat_vaddr_q, xlat_vaddr_d, err_vaddr_q, err_vaddr_d;
  logic [1:0]         err_cause_q, err_cause_d, dc_size_q, dc_size_d;
  logic [INDEX_W-1:0] dc_index_q, dc_index_d;
  logic [TAG_W-1:0]   dc_tag_q, dc_tag_d;
  logic [XLEN-1:0]    dc_wdata_q, dc_wdata_d;
  logic [BE_W-1:0]    dc_be_q, dc_be_d;

  assign push = req_valid_i && req_ready_o;

  l1_dcache_req_fifo #(.DEPTH(DEPTH), .WIDTH(ENT_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i ({req_op_i, req_vaddr_i, req_wdata_i, req_size_i}),
    .pop_i   (pop_c),
    .rdata_o (head),
    .ready_o (req_ready_o),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign {head_op, head_vaddr, head_wdata, head_size} = head;
  assign head_off = head_vaddr[OFF_W-1:0];
  assign misalign = (head_size > 2'(OFF_W)) ||
                    (|(head_off & OFF_W'((32'd1 << head_size) - 32'd1)));
  // After popping the head, another entry is present if one was behind it or arrives now.
  assign remain   = (fifo_count > CNT_W'(1)) || push;

  always_comb begin
    state_d      = state_q;
    pop_c        = 1'b0;
    xlat_vaddr_d = xlat_vaddr_q;
    err_cause_d  = err_cause_q;
    err_vaddr_d  = err_vaddr_q;
    dc_we_d      = dc_we_q;
    dc_index_d   = dc_index_q;
    dc_tag_d     = dc_tag_q;
    dc_wdata_d   = dc_wdata_q;
    dc_be_d      = dc_be_q;
    dc_size_d    = dc_size_q;
    case (state_q)
      S_IDLE: if (!fifo_empty || push) state_d = S_CHECK;
      S_CHECK: begin
        if (misalign) begin
          state_d     = S_ERR;
          err_cause_d = CAUSE_MISALIGN;
          err_vaddr_d = head_vaddr;
        end else begin
          state_d      = S_XLATE;
          xlat_vaddr_d = head_vaddr;
        end
      end
      S_XLATE: begin
        if (xlat_valid_i && xlat_fault_i) begin
          state_d     = S_ERR;
          err_cause_d = CAUSE_PFAULT;
          err_vaddr_d = head_vaddr;
        end else if (xlat_valid_i) begin
          state_d    = S_ISSUE;
          dc_we_d    = (head_op == OP_STORE) || (head_op == OP_AMO);
          dc_index_d = xlat_paddr_i[INDEX_W-1:0];
          dc_tag_d   = xlat_paddr_i[PADDR_W-1:INDEX_W];
          dc_wdata_d = head_wdata << {head_off, 3'b000};
          dc_be_d    = BE_W'(be_gen(head_size, 3'(head_off)));
          dc_size_d  = head_size;
        end
      end
      S_ISSUE: begin
        if (dc_req_ready_i) begin
          pop_c   = 1'b1;
          state_d = remain ? S_CHECK : S_IDLE;
        end
      end
      S_ERR: begin
        pop_c   = 1'b1;
        state_d = remain ? S_CHECK : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    xlat_req_d  = (state_d == S_XLATE);
    dc_valid_d  = (state_d == S_ISSUE);
    err_valid_d = (state_d == S_ERR);
    empty_d     = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      xlat_req_q   <= 1'b0;
      xlat_vaddr_q <= '0;
      dc_valid_q   <= 1'b0;
      dc_we_q      <= 1'b0;
      dc_index_q   <= '0;
      dc_tag_q     <= '0;
      dc_wdata_q   <= '0;
      dc_be_q      <= '0;
      dc_size_q    <= '0;
      err_valid_q  <= 1'b0;
      err_cause_q  <= '0;
      err_vaddr_q  <= '0;
      empty_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      xlat_req_q   <= xlat_req_d;
      xlat_vaddr_q <= xlat_vaddr_d;
      dc_valid_q   <= dc_valid_d;
      dc_we_q      <= dc_we_d;
      dc_index_q   <= dc_index_d;
      dc_tag_q     <= dc_tag_d;
      dc_wdata_q   <= dc_wdata_d;
      dc_be_q      <= dc_be_d;
      dc_size_q    <= dc_size_d;
      err_valid_q  <= err_valid_d;
      err_cause_q  <= err_cause_d;
      err_vaddr_q  <= err_vaddr_d;
      empty_q      <= empty_d;
    end
  end

  assign xlat_req_o     = xlat_req_q;
  assign xlat_vaddr_o   = xlat_vaddr_q;
  assign dc_req_valid_o = dc_valid_q;
  assign dc_req_we_o    = dc_we_q;
  assign dc_req_index_o = dc_index_q;
  assign dc_req_tag_o   = dc_tag_q;
  assign dc_req_wdata_o = dc_wdata_q;
  assign dc_req_be_o    = dc_be_q;
  assign dc_req_size_o  = dc_size_q;
  assign err_valid_o    = err_valid_q;
  assign err_cause_o    = err_cause_q;
  assign err_vaddr_o    = err_vaddr_q;
  assign empty_o        = empty_q;
  assign drain_nc_o     = req_valid_i | !empty_q;

endmodule

// File: tb/tb_l1_dcache_lsq_adapter.sv
// Scoreboard bench for l1_dcache_lsq_adapter with MMU and dcache response models.
module tb_l1_dcache_lsq_adapter;
  localparam int unsigned XLEN = 64, PADDR_W = 56, INDEX_W = 11, DEPTH = 4;

  logic clk = 1'b0, rst = 1'b0;
  logic req_valid_i = 1'b0, req_ready_o;
  logic [1:0] req_op_i = '0, req_size_i = '0;
  logic [63:0] req_vaddr_i = '0, req_wdata_i = '0;
  logic xlat_req_o, xlat_valid_i = 1'b0, xlat_fault_i = 1'b0;
  logic [63:0] xlat_vaddr_o;
  logic [PADDR_W-1:0] xlat_paddr_i = '0;
  logic dc_req_valid_o, dc_req_ready_i = 1'b0, dc_req_we_o;
  logic [INDEX_W-1:0] dc_req_index_o;
  logic [PADDR_W-INDEX_W-1:0] dc_req_tag_o;
  logic [XLEN-1:0] dc_req_wdata_o;
  logic [XLEN/8-1:0] dc_req_be_o;
  logic [1:0] dc_req_size_o, err_cause_o;
  logic err_valid_o, empty_o, drain_nc_o;
  logic [63:0] err_vaddr_o;

  always #5 clk = ~clk;

  l1_dcache_lsq_adapter #(.XLEN(XLEN), .PADDR_W(PADDR_W), .INDEX_W(INDEX_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_vaddr_i(req_vaddr_i), .req_wdata_i(req_wdata_i), .req_size_i(req_size_i),
    .xlat_req_o(xlat_req_o), .xlat_vaddr_o(xlat_vaddr_o), .xlat_valid_i(xlat_valid_i),
    .xlat_fault_i(xlat_fault_i), .xlat_paddr_i(xlat_paddr_i),
    .dc_req_valid_o(dc_req_valid_o), .dc_req_ready_i(dc_req_ready_i), .dc_req_we_o(dc_req_we_o),
    .dc_req_index_o(dc_req_index_o), .dc_req_tag_o(dc_req_tag_o), .dc_req_wdata_o(dc_req_wdata_o),
    .dc_req_be_o(dc_req_be_o), .dc_req_size_o(dc_req_size_o),
    .err_valid_o(err_valid_o), .err_cause_o(err_cause_o), .err_vaddr_o(err_vaddr_o),
    .empty_o(empty_o), .drain_nc_o(drain_nc_o)
  );

  typedef struct {
    bit          is_err;
    logic [1:0]  cause;
    logic [63:0] vaddr;
    logic        we;
    logic [10:0] index;
    logic [44:0] tag;
    logic [63:0] wdata;
    logic [7:0]  be;
    logic [1:0]  size;
  } exp_t;

  exp_t sb[$];
  int checks = 0, failures = 0;
  int n_xlat = 0, n_dc = 0, n_err = 0, mmu_lat = 0, xcnt = 0;
  bit dc_hold = 1'b0, prev_stall = 1'b0, prev_err = 1'b0;
  logic [63:0] fault_vaddr = '1;
  logic [130:0] snap = '0, cur;

  task automatic expect_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [63:0] va,
                                 input logic [63:0] wd, input logic [1:0] sz);
    exp_t e;
    int unsigned off, nb;
    logic [55:0] pa;
    e = '{default: 0};
    off = 32'(va[2:0]);
    nb  = 32'd1 << sz;
    if ((off % nb) != 0) begin
      e.is_err = 1'b1; e.cause = 2'b01; e.vaddr = va;
    end else if (va == fault_vaddr) begin
      e.is_err = 1'b1; e.cause = 2'b10; e.vaddr = va;
    end else begin
      pa      = va[55:0] | 56'h8000_0000;
      e.index = pa[10:0];
      e.tag   = pa[55:11];
      e.wdata = wd << (8 * off);
      e.be    = 8'(((32'd1 << nb) - 32'd1) << off);
      e.we    = (op == 2'b01) || (op == 2'b10);
      e.size  = sz;
    end
    return e;
  endfunction

  task automatic sb_compare(input bit is_err);
    exp_t e;
    expect_eq("sb_nonempty", 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      expect_eq("kind_is_err", 64'(is_err), 64'(e.is_err));
      if (is_err && e.is_err) begin
        expect_eq("err_cause", 64'(err_cause_o), 64'(e.cause));
        expect_eq("err_vaddr", err_vaddr_o, e.vaddr);
      end else if (!is_err && !e.is_err) begin
        expect_eq("dc_we", 64'(dc_req_we_o), 64'(e.we));
        expect_eq("dc_index", 64'(dc_req_index_o), 64'(e.index));
        expect_eq("dc_tag", 64'(dc_req_tag_o), 64'(e.tag));
        expect_eq("dc_wdata", 64'(dc_req_wdata_o), e.wdata);
        expect_eq("dc_be", 64'(dc_req_be_o), 64'(e.be));
        expect_eq("dc_size", 64'(dc_req_size_o), 64'(e.size));
      end
    end
  endtask

  // MMU and dcache responders plus output monitor, all on the falling edge.
  initial forever begin
    @(negedge clk);
    if (xlat_req_o === 1'b1) xcnt++; else xcnt = 0;
    if (xcnt == 1) n_xlat++;
    xlat_valid_i   = (xlat_req_o === 1'b1) && (xcnt > mmu_lat);
    xlat_fault_i   = xlat_valid_i && (xlat_vaddr_o == fault_vaddr);
    xlat_paddr_i   = xlat_vaddr_o[55:0] | 56'h8000_0000;
    dc_req_ready_i = (dc_req_valid_o === 1'b1) && !dc_hold;
    cur = {dc_req_we_o, dc_req_index_o, dc_req_tag_o, dc_req_wdata_o, dc_req_be_o, dc_req_size_o};
    if (dc_req_valid_o === 1'b1 && prev_stall) expect_eq("dc_stable", 64'(cur == snap), 64'd1);
    snap       = cur;
    prev_stall = (dc_req_valid_o === 1'b1) && !dc_req_ready_i;
    if (dc_req_valid_o === 1'b1 && dc_req_ready_i) begin n_dc++; sb_compare(1'b0); end
    if (err_valid_o === 1'b1) begin
      n_err++;
      expect_eq("err_one_cycle", 64'(prev_err), 64'd0);
      sb_compare(1'b1);
    end
    prev_err = (err_valid_o === 1'b1);
  end

  task automatic push_req(input logic [1:0] op, input logic [63:0] va,
                          input logic [63:0] wd, input logic [1:0] sz);
    bit done = 1'b0;
    req_valid_i = 1'b1; req_op_i = op; req_vaddr_i = va; req_wdata_i = wd; req_size_i = sz;
    for (int i = 0; i < 300 && !done; i++) begin
      done = req_ready_o;
      @(posedge clk); #1;
    end
    req_valid_i = 1'b0;
    if (done) sb.push_back(model(op, va, wd, sz));
    else expect_eq("push_timeout", 64'(done), 64'd1);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(posedge clk); #1;
      ok = empty_o && (sb.size() == 0);
    end
    expect_eq("idle_reached", 64'(ok), 64'd1);
  endtask

  initial begin
    int x0, d0, e0;
    bit seen;
    logic [63:0] tv_va [6] = '{64'h2001, 64'h7FF8, 64'h12346, 64'h4000_0013, 64'hFFFF_0006, 64'h5};
    logic [63:0] tv_wd [6] = '{64'h11, 64'h1122_3344_5566_7788, 64'hBEEF, 64'h5A, 64'h1234, 64'h77};
    logic [1:0]  tv_op [6] = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b01, 2'b00};
    logic [1:0]  tv_sz [6] = '{2'd0, 2'd3, 2'd1, 2'd0, 2'd1, 2'd2};

    repeat (3) @(posedge clk);
    #1;
    expect_eq("rst_ready", 64'(req_ready_o), 64'd1);
    expect_eq("rst_empty", 64'(empty_o), 64'd1);
    expect_eq("rst_xlat_req", 64'(xlat_req_o), 64'd0);
    expect_eq("rst_dc_valid", 64'(dc_req_valid_o), 64'd0);
    expect_eq("rst_err_valid", 64'(err_valid_o), 64'd0);
    expect_eq("rst_dc_be", 64'(dc_req_be_o), 64'd0);
    expect_eq("rst_drain", 64'(drain_nc_o), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Aligned store with exact latency checks.
    push_req(2'b01, 64'h1004, 64'hAABB_CCDD, 2'd2);
    expect_eq("t1_no_xlat_in_check", 64'(xlat_req_o), 64'd0);
    expect_eq("t1_not_empty", 64'(empty_o), 64'd0);
    expect_eq("t1_drain", 64'(drain_nc_o), 64'd1);
    @(posedge clk); #1;
    expect_eq("t1_xlat_req_t2", 64'(xlat_req_o), 64'd1);
    expect_eq("t1_xlat_vaddr", xlat_vaddr_o, 64'h1004);
    expect_eq("t1_no_dc_t2", 64'(dc_req_valid_o), 64'd0);
    @(posedge clk); #1;
    expect_eq("t1_dc_valid_t3", 64'(dc_req_valid_o), 64'd1);
    expect_eq("t1_be", 64'(dc_req_be_o), 64'hF0);
    expect_eq("t1_wdata", 64'(dc_req_wdata_o), 64'hAABB_CCDD_0000_0000);
    expect_eq("t1_index", 64'(dc_req_index_o), 64'h004);
    expect_eq("t1_tag", 64'(dc_req_tag_o), 64'h8000_1004 >> 11);
    expect_eq("t1_we", 64'(dc_req_we_o), 64'd1);
    wait_idle();

    // Misaligned load: error only, no translation.
    x0 = n_xlat; e0 = n_err;
    push_req(2'b00, 64'h3, 64'h0, 2'd1);
    wait_idle();
    expect_eq("mis_no_xlat", 64'(n_xlat - x0), 64'd0);
    expect_eq("mis_one_err", 64'(n_err - e0), 64'd1);

    // Mixed directed and random traffic, back to back.
    for (int i = 0; i < 6; i++) push_req(tv_op[i], tv_va[i], tv_wd[i], tv_sz[i]);
    for (int i = 0; i < 10; i++)
      push_req(2'($urandom), {16'h0, 16'($urandom), 32'($urandom)},
               {32'($urandom), 32'($urandom)}, 2'($urandom));
    wait_idle();

    // Page fault on the third XLATE cycle; next entry still issues.
    mmu_lat = 2; fault_vaddr = 64'h9000;
    d0 = n_dc; e0 = n_err;
    push_req(2'b00, 64'h9000, 64'h0, 2'd3);
    push_req(2'b01, 64'hA008, 64'hCAFE, 2'd3);
    wait_idle();
    expect_eq("pf_one_err", 64'(n_err - e0), 64'd1);
    expect_eq("pf_one_dc", 64'(n_dc - d0), 64'd1);
    mmu_lat = 0; fault_vaddr = '1;

    // Backpressure: fields held while the dcache stalls.
    dc_hold = 1'b1; d0 = n_dc; seen = 1'b0;
    push_req(2'b01, 64'h2_0002, 64'h00C3, 2'd0);
    for (int i = 0; i < 20 && !seen; i++) begin @(posedge clk); #1; seen = dc_req_valid_o; end
    expect_eq("bp_dc_valid", 64'(seen), 64'd1);
    repeat (5) @(posedge clk);
    #1;
    expect_eq("bp_no_handshake", 64'(n_dc - d0), 64'd0);
    expect_eq("bp_valid_held", 64'(dc_req_valid_o), 64'd1);
    dc_hold = 1'b0;
    wait_idle();
    expect_eq("bp_single_handshake", 64'(n_dc - d0), 64'd1);

    // Fill, stall, then release and wrap pointers.
    dc_hold = 1'b1; d0 = n_dc;
    for (int i = 0; i < DEPTH; i++) push_req(2'b01, 64'h3000 + 64'(8 * i), 64'(i + 1), 2'd3);
    expect_eq("full_ready_low", 64'(req_ready_o), 64'd0);
    fork
      begin
        push_req(2'b00, 64'h4000, 64'h0, 2'd2);
        push_req(2'b01, 64'h4006, 64'hABCD, 2'd1);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        expect_eq("full_ready_still_low", 64'(req_ready_o), 64'd0);
        dc_hold = 1'b0;
      end
    join
    wait_idle();
    expect_eq("fill_all_issued", 64'(n_dc - d0), 64'(DEPTH + 2));
    expect_eq("fill_empty", 64'(empty_o), 64'd1);

    // Reset while stuck in XLATE with three entries queued.
    mmu_lat = 1000; seen = 1'b0;
    for (int i = 0; i < 3; i++) push_req(2'b01, 64'h5000 + 64'(8 * i), 64'h99, 2'd3);
    for (int i = 0; i < 20 && !seen; i++) begin seen = xlat_req_o; if (!seen) begin @(posedge clk); #1; end end
    expect_eq("rr_in_xlate", 64'(seen), 64'd1);
    e0 = n_err;
    rst = 1'b0;
    @(posedge clk); #1;
    sb.delete();
    expect_eq("rr_xlat_req", 64'(xlat_req_o), 64'd0);
    expect_eq("rr_xlat_vaddr", xlat_vaddr_o, 64'd0);
    expect_eq("rr_dc_valid", 64'(dc_req_valid_o), 64'd0);
    expect_eq("rr_err_valid", 64'(err_valid_o), 64'd0);
    expect_eq("rr_ready", 64'(req_ready_o), 64'd1);
    expect_eq("rr_empty", 64'(empty_o), 64'd1);
    rst = 1'b1; mmu_lat = 0;
    repeat (4) @(posedge clk);
    #1;
    expect_eq("rr_stays_empty", 64'(empty_o), 64'd1);
    expect_eq("rr_no_err", 64'(n_err - e0), 64'd0);
    push_req(2'b00, 64'h6008, 64'h0, 2'd3);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
